// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_if
// Purpose  : Bundles the writeback, read-port and scoreboard signals of the
//            register file into one interface.
//   master : decode/writeback side, drives the in_* signals, observes out_*.
//   slave  : register file, observes in_* signals, drives out_*.
// Revision : 1.0  initial release
// ============================================================================
interface register_file_if #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4
);
    logic                       in_act_write_res_to_reg;
    logic [IALU_WORD_WIDTH-1:0] in_res;
    logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx;
    logic [REG_IDX_WIDTH-1:0]   in_rd_idx_a;
    logic [REG_IDX_WIDTH-1:0]   in_rd_idx_b;
    logic                       in_rd_use_a;
    logic                       in_rd_use_b;
    logic                       in_sb_set;
    logic [REG_IDX_WIDTH-1:0]   in_sb_set_idx;
    logic [IALU_WORD_WIDTH-1:0] out_rd_data_a;
    logic [IALU_WORD_WIDTH-1:0] out_rd_data_b;
    logic                       out_busy_a;
    logic                       out_busy_b;
    logic                       out_stall;
    logic [REG_IDX_WIDTH:0]     out_pending_cnt;
    logic                       out_sb_err;

    modport master (
        output in_act_write_res_to_reg, in_res, in_res_reg_idx,
               in_rd_idx_a, in_rd_idx_b, in_rd_use_a, in_rd_use_b,
               in_sb_set, in_sb_set_idx,
        input  out_rd_data_a, out_rd_data_b, out_busy_a, out_busy_b,
               out_stall, out_pending_cnt, out_sb_err
    );

    modport slave (
        input  in_act_write_res_to_reg, in_res, in_res_reg_idx,
               in_rd_idx_a, in_rd_idx_b, in_rd_use_a, in_rd_use_b,
               in_sb_set, in_sb_set_idx,
        output out_rd_data_a, out_rd_data_b, out_busy_a, out_busy_b,
               out_stall, out_pending_cnt, out_sb_err
    );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : NUM_REGS x IALU_WORD_WIDTH register file with two combinational
//            read ports, write-to-read bypass, and a busy-bit scoreboard that
//            drives the decode stall, a pending count and a sticky error flag.
// Ports    : clock - rising-edge clock
//            reset - asynchronous active-high reset
//            bus   - register_file_if.slave (write, read, scoreboard, status)
// Revision : 1.0  initial release
// ============================================================================
module register_file #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4
) (
    input  wire logic        clock,
    input  wire logic        reset,
    register_file_if.slave   bus
);
    localparam int NUM_REGS = 2 ** REG_IDX_WIDTH;
    localparam int CNT_W    = REG_IDX_WIDTH + 1;

    logic [IALU_WORD_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]        busy_q;
    logic [NUM_REGS-1:0]        busy_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;
    logic                       err_q;
    logic                       err_d;
    logic                       waw;
    logic                       write_no_issue;

    wire logic we       = bus.in_act_write_res_to_reg;
    wire logic hit_a    = we && (bus.in_res_reg_idx == bus.in_rd_idx_a);
    wire logic hit_b    = we && (bus.in_res_reg_idx == bus.in_rd_idx_b);
    wire logic set_clr  = bus.in_sb_set && we &&
                          (bus.in_sb_set_idx == bus.in_res_reg_idx);

    // Next scoreboard state: clear first so a same-index set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (we)
            busy_d[bus.in_res_reg_idx] = 1'b0;
        if (bus.in_sb_set)
            busy_d[bus.in_sb_set_idx] = 1'b1;

        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++)
            cnt_d = cnt_d + CNT_W'(busy_d[i]);

        // A same-cycle clear of the target retires the old writer, so a
        // re-issue is legal; likewise a write to a just-issued index is legal.
        waw            = bus.in_sb_set && busy_q[bus.in_sb_set_idx] && !set_clr;
        write_no_issue = we && !busy_q[bus.in_res_reg_idx] && !set_clr;
        err_d          = err_q | waw | write_no_issue;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (we)
                regs_q[bus.in_res_reg_idx] <= bus.in_res;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Bypass supplies the in-flight result, so a matching source is not busy.
    assign bus.out_rd_data_a   = hit_a ? bus.in_res : regs_q[bus.in_rd_idx_a];
    assign bus.out_rd_data_b   = hit_b ? bus.in_res : regs_q[bus.in_rd_idx_b];
    assign bus.out_busy_a      = busy_q[bus.in_rd_idx_a] && !hit_a;
    assign bus.out_busy_b      = busy_q[bus.in_rd_idx_b] && !hit_b;
    assign bus.out_stall       = (bus.in_rd_use_a && bus.out_busy_a) ||
                                 (bus.in_rd_use_b && bus.out_busy_b);
    assign bus.out_pending_cnt = cnt_q;
    assign bus.out_sb_err      = err_q;
endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Self-checking bench for register_file: directed scenarios with
//            literal expectations plus a per-cycle comparison against a
//            behavioural model of registers, busy set and error flag.
// Revision : 1.0  initial release
// ============================================================================
module tb_register_file;
    localparam int W = 16;
    localparam int I = 4;
    localparam int N = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   cmp_en = 1'b0;

    register_file_if #(.IALU_WORD_WIDTH(W), .REG_IDX_WIDTH(I)) bus ();

    register_file #(.IALU_WORD_WIDTH(W), .REG_IDX_WIDTH(I)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_regs [N];
    bit           m_busy [N];
    bit           m_err;

    initial begin
        for (int k = 0; k < N; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
        m_err = 1'b0;
    end

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < N; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            bit we, st, same;
            int wi, si;
            we   = bus.in_act_write_res_to_reg;
            st   = bus.in_sb_set;
            wi   = int'(bus.in_res_reg_idx);
            si   = int'(bus.in_sb_set_idx);
            same = we && st && (wi == si);
            if (st && m_busy[si] && !same) m_err = 1'b1;
            if (we && !m_busy[wi] && !same) m_err = 1'b1;
            if (we) begin
                m_regs[wi] = bus.in_res;
                m_busy[wi] = 1'b0;
            end
            if (st) m_busy[si] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, sampled mid-cycle with inputs stable.
    always @(negedge clock) begin
        if (cmp_en) begin
            logic [W-1:0] ea, eb;
            bit ba, bb, ha, hb;
            int ra, rb, wi;
            ra = int'(bus.in_rd_idx_a);
            rb = int'(bus.in_rd_idx_b);
            wi = int'(bus.in_res_reg_idx);
            ha = bus.in_act_write_res_to_reg && (wi == ra);
            hb = bus.in_act_write_res_to_reg && (wi == rb);
            ea = ha ? bus.in_res : m_regs[ra];
            eb = hb ? bus.in_res : m_regs[rb];
            ba = m_busy[ra] && !ha;
            bb = m_busy[rb] && !hb;
            check("model_data_a", 32'(bus.out_rd_data_a), 32'(ea));
            check("model_data_b", 32'(bus.out_rd_data_b), 32'(eb));
            check("model_busy_a", 32'(bus.out_busy_a), 32'(ba));
            check("model_busy_b", 32'(bus.out_busy_b), 32'(bb));
            check("model_stall", 32'(bus.out_stall),
                  32'((bus.in_rd_use_a && ba) || (bus.in_rd_use_b && bb)));
            check("model_cnt", 32'(bus.out_pending_cnt), 32'(m_count()));
            check("model_err", 32'(bus.out_sb_err), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.in_act_write_res_to_reg = 1'b0;
        bus.in_res         = '0;
        bus.in_res_reg_idx = '0;
        bus.in_rd_idx_a    = '0;
        bus.in_rd_idx_b    = '0;
        bus.in_rd_use_a    = 1'b0;
        bus.in_rd_use_b    = 1'b0;
        bus.in_sb_set      = 1'b0;
        bus.in_sb_set_idx  = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int idx, input logic [W-1:0] val);
        bus.in_act_write_res_to_reg = 1'b1;
        bus.in_res_reg_idx = I'(idx);
        bus.in_res         = val;
    endtask

    task automatic sbset(input int idx);
        bus.in_sb_set     = 1'b1;
        bus.in_sb_set_idx = I'(idx);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        step();
        // Bypass and quiet status while held in reset.
        wr(3, 16'h5555);
        bus.in_rd_idx_a = 4'd3;
        bus.in_rd_idx_b = 4'd4;
        bus.in_rd_use_a = 1'b1;
        bus.in_rd_use_b = 1'b1;
        #1;
        check("rst_bypass_a", 32'(bus.out_rd_data_a), 32'h5555);
        check("rst_data_b", 32'(bus.out_rd_data_b), 32'h0);
        check("rst_stall", 32'(bus.out_stall), 32'h0);
        check("rst_cnt", 32'(bus.out_pending_cnt), 32'h0);
        check("rst_err", 32'(bus.out_sb_err), 32'h0);
        step();
        idle();
        step();
        reset = 1'b0;

        // Write then read next cycle.
        wr(5, 16'h1234);
        step();
        idle();
        bus.in_rd_idx_a = 4'd5;
        #1;
        check("wr_rd_a", 32'(bus.out_rd_data_a), 32'h1234);
        check("wr_rd_busy", 32'(bus.out_busy_a), 32'h0);
        check("wr_rd_cnt", 32'(bus.out_pending_cnt), 32'h0);

        // Same-cycle bypass on port B.
        step();
        wr(3, 16'hBEEF);
        bus.in_rd_idx_b = 4'd3;
        #1;
        check("bypass_b", 32'(bus.out_rd_data_b), 32'hBEEF);
        step();
        idle();
        bus.in_rd_idx_b = 4'd3;
        #1;
        check("stored_b", 32'(bus.out_rd_data_b), 32'hBEEF);

        do_reset();

        // Stall on busy source, released by same-cycle writeback.
        sbset(7);
        step();
        idle();
        bus.in_rd_idx_a = 4'd7;
        bus.in_rd_use_a = 1'b1;
        #1;
        check("stall_on", 32'(bus.out_stall), 32'h1);
        check("stall_cnt", 32'(bus.out_pending_cnt), 32'h1);
        wr(7, 16'h00AA);
        #1;
        check("stall_off", 32'(bus.out_stall), 32'h0);
        check("stall_data", 32'(bus.out_rd_data_a), 32'h00AA);
        step();
        idle();
        #1;
        check("cnt_after_wb", 32'(bus.out_pending_cnt), 32'h0);
        check("err_clean", 32'(bus.out_sb_err), 32'h0);

        // Same-edge set and clear of a busy index: set wins.
        sbset(2);
        step();
        sbset(2);
        wr(2, 16'h1111);
        step();
        idle();
        bus.in_rd_idx_a = 4'd2;
        #1;
        check("setclr_busy", 32'(bus.out_busy_a), 32'h1);
        check("setclr_cnt", 32'(bus.out_pending_cnt), 32'h1);
        check("setclr_err", 32'(bus.out_sb_err), 32'h0);
        wr(2, 16'h2222);
        step();
        idle();

        // Fill the scoreboard completely; unused busy source never stalls.
        for (int k = 0; k < N; k++) begin
            sbset(k);
            step();
        end
        idle();
        bus.in_rd_idx_b = 4'd9;
        #1;
        check("full_cnt", 32'(bus.out_pending_cnt), 32'd16);
        check("unused_busy_b", 32'(bus.out_busy_b), 32'h1);
        check("unused_nostall", 32'(bus.out_stall), 32'h0);
        for (int k = 0; k < N; k++) begin
            wr(k, W'(k * 16'h0111));
            step();
        end
        idle();
        #1;
        check("drain_cnt", 32'(bus.out_pending_cnt), 32'h0);
        check("drain_err", 32'(bus.out_sb_err), 32'h0);

        // Double issue without writeback sets the sticky error.
        sbset(4);
        step();
        sbset(4);
        step();
        idle();
        #1;
        check("waw_err", 32'(bus.out_sb_err), 32'h1);
        wr(4, 16'h4444);
        step();
        idle();
        step();
        check("waw_sticky", 32'(bus.out_sb_err), 32'h1);

        // Asynchronous reset mid-cycle with pending scoreboard entries.
        sbset(1);
        step();
        sbset(2);
        step();
        sbset(3);
        step();
        idle();
        bus.in_rd_idx_a = 4'd1;
        bus.in_rd_idx_b = 4'd3;
        bus.in_rd_use_a = 1'b1;
        #1;
        check("pre_rst_cnt", 32'(bus.out_pending_cnt), 32'h3);
        check("pre_rst_data", 32'(bus.out_rd_data_a), 32'h0111);
        #1 reset = 1'b1;
        #1;
        check("arst_cnt", 32'(bus.out_pending_cnt), 32'h0);
        check("arst_busy_a", 32'(bus.out_busy_a), 32'h0);
        check("arst_data_a", 32'(bus.out_rd_data_a), 32'h0);
        check("arst_data_b", 32'(bus.out_rd_data_b), 32'h0);
        check("arst_err", 32'(bus.out_sb_err), 32'h0);
        check("arst_stall", 32'(bus.out_stall), 32'h0);
        step();
        reset = 1'b0;
        wr(1, 16'h4242);
        step();
        idle();
        bus.in_rd_idx_a = 4'd1;
        #1;
        check("post_rst_data", 32'(bus.out_rd_data_a), 32'h4242);
        check("post_rst_err", 32'(bus.out_sb_err), 32'h1);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
